// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared register-file constants and writeback source select
package writeback_unit_pkg;
  localparam int REG_DATA_W = 64;
  localparam int REG_ADDR_W = 5;
  localparam int XZR_IDX = 31;
  localparam int WB_FIFO_DEPTH = 4;
  localparam int WB_STARVE_LIMIT = 4;
  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_FIFO} wb_src_e;
endpackage

// File: rtl/writeback_unit_fifo.sv
// wb_fifo: load-result FIFO exposing every slot and its valid bit for forwarding
module wb_fifo
  import writeback_unit_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH = WB_FIFO_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_W-1:0]              push_reg,
  input  logic [DATA_W-1:0]              push_data,
  output logic                           full,
  output logic                           empty,
  output logic [CW-1:0]                  count,
  output logic [PW-1:0]                  rd_ptr,
  output logic [DEPTH-1:0][ADDR_W-1:0]   ent_reg,
  output logic [DEPTH-1:0][DATA_W-1:0]   ent_data,
  output logic [DEPTH-1:0]               ent_valid
);
  logic [PW-1:0] wr_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        ent_reg[wr_ptr] <= push_reg;
        ent_data[wr_ptr] <= push_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    assign ent_valid[g] = {1'b0, PW'(g) - rd_ptr} < count;
  end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU and queued load results onto the register-file write port
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH = WB_FIFO_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                     write_clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_reg,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_reg,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     regWrite,
  output logic [ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        fwd_reg,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic full, empty, alu_take, pop;
  logic [PW-1:0] rd_ptr, idx;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_reg;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [DEPTH-1:0] ent_valid;
  logic [SW-1:0] starve_cnt;
  logic [ADDR_W-1:0] nxt_reg;
  logic [DATA_W-1:0] nxt_data;
  wb_src_e src;
  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(write_clk), .rst(reset), .push(mem_valid && mem_ready), .pop(pop),
    .push_reg(mem_reg), .push_data(mem_data), .full(full), .empty(empty),
    .count(pending), .rd_ptr(rd_ptr), .ent_reg(ent_reg), .ent_data(ent_data),
    .ent_valid(ent_valid)
  );
  assign mem_ready = !full;
  // A saturated starve counter blocks the ALU, so the forced drain falls out of the FIFO-when-idle path
  always_comb begin
    alu_ready = starve_cnt != SW'(STARVE_LIMIT);
    alu_take = alu_valid && alu_ready;
    pop = !empty && !alu_take;
    src = alu_take ? SRC_ALU : pop ? SRC_FIFO : SRC_NONE;
    nxt_reg = alu_take ? alu_reg : ent_reg[rd_ptr];
    nxt_data = alu_take ? alu_data : ent_data[rd_ptr];
  end
  always_ff @(posedge write_clk) begin
    if (reset) begin
      regWrite <= 1'b0;
      write_reg <= '0;
      write_data <= '0;
      starve_cnt <= '0;
    end else begin
      regWrite <= src != SRC_NONE && nxt_reg != ADDR_W'(XZR_IDX);
      if (src != SRC_NONE) begin
        write_reg <= nxt_reg;
        write_data <= nxt_data;
      end
      starve_cnt <= (empty || pop) ? '0 : starve_cnt + SW'(alu_ready);
    end
  end
  // Output register first, then FIFO oldest to newest so the youngest match wins
  always_comb begin
    fwd_hit = 1'b0;
    fwd_data = '0;
    idx = '0;
    if (regWrite && write_reg == fwd_reg) begin
      fwd_hit = 1'b1;
      fwd_data = write_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + i[PW-1:0];
      if (ent_valid[idx] && ent_reg[idx] == fwd_reg) begin
        fwd_hit = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
    if (fwd_reg == ADDR_W'(XZR_IDX)) begin
      fwd_hit = 1'b0;
      fwd_data = '0;
    end
  end
endmodule
